// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with single-word fills.
// It also keeps hit and miss counters for performance runs.
module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS)
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FETCH = 1'b1;

  logic [0:0]       r_state;
  logic [29:0]      r_missAddr;
  logic [SETS-1:0]  r_valid;
  logic [TAG_W-1:0] r_tag  [0:SETS-1];
  logic [31:0]      r_data [0:SETS-1];

  logic [IDX_W-1:0] w_idx;
  logic [TAG_W-1:0] w_tag;
  logic [IDX_W-1:0] w_fillIdx;
  logic [TAG_W-1:0] w_fillTag;
  logic             w_hit;
  logic             w_miss;
  logic             w_fillDone;
  logic [1:0]       w_unusedLowBits;

  assign w_idx           = imemaddr[IDX_W+1:2];
  assign w_tag           = imemaddr[31:IDX_W+2];
  assign w_fillIdx       = r_missAddr[IDX_W-1:0];
  assign w_fillTag       = r_missAddr[29:IDX_W];
  assign w_unusedLowBits = imemaddr[1:0];

  assign w_hit      = imemREN && (r_state == IDLE) && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_miss     = imemREN && (r_state == IDLE) && !w_hit;
  assign w_fillDone = (r_state == FETCH) && !iwait;

  assign ihit     = w_hit;
  assign imemload = w_hit ? r_data[w_idx] : 32'd0;
  assign iREN     = (r_state == FETCH);
  assign iaddr    = (r_state == FETCH) ? {r_missAddr, 2'b00} : 32'd0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_missAddr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_miss) begin
            r_state    <= FETCH;
            r_missAddr <= imemaddr[31:2];
          end
        end
        default: begin
          if (!iwait) r_state <= IDLE;
        end
      endcase
    end
  end

  // A flush clears every line, but a fill landing on the same edge still sets its own line.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_valid <= '0;
    end else begin
      if (iflush) r_valid <= '0;
      if (w_fillDone) r_valid[w_fillIdx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (w_fillDone) begin
      r_tag[w_fillIdx]  <= w_fillTag;
      r_data[w_fillIdx] <= iload;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (w_hit)  hit_count  <= hit_count + 32'd1;
      if (w_miss) miss_count <= miss_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: a stalling memory model feeds fills and a
// scoreboard queue holds the instruction word each fetch should return.
module tb_icache;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        imemREN = 1'b0;
  logic [31:0] imemaddr = 32'd0;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush = 1'b0;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait = 1'b1;
  logic [31:0] iload;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int checkCount = 0;
  int badCount   = 0;
  int waitN      = 0;
  int memCnt     = 0;
  int expHits    = 0;
  int expMisses  = 0;
  logic [31:0] expQ [$];

  icache #(.SETS(16)) dut (
    .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
    .ihit(ihit), .imemload(imemload), .iflush(iflush), .iREN(iREN),
    .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == 32'h40) return 32'h2001_000A;
    return {~w[15:0], w[15:0]};
  endfunction

  assign iload = memWord(iaddr);

  // Memory model: holds iwait high for waitN cycles of each fill request.
  always @(negedge CLK) begin
    if (iREN) begin
      iwait = (memCnt < waitN);
      memCnt = memCnt + 1;
    end else begin
      memCnt = 0;
      iwait = 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_hits"}, hit_count, expHits);
    checkOutput({tag, "_misses"}, miss_count, expMisses);
  endtask

  // Issue one fetch and wait for the hit; expectHit selects 0-cycle or waitN+2 latency.
  task automatic applyStimulus(input logic [31:0] addr, input bit expectHit, input bit flushOnFill);
    int cycles;
    int renCycles;
    logic [31:0] exp;
    cycles = 0;
    renCycles = 0;
    imemREN = 1'b1;
    imemaddr = addr;
    expQ.push_back(memWord(addr));
    #1;
    while (!ihit && cycles < 50) begin
      if (iREN) begin
        renCycles++;
        checkOutput("fillAddr", iaddr, addr & 32'hFFFF_FFFC);
        if (flushOnFill && !iwait) iflush = 1'b1;
      end
      @(negedge CLK);
      #1;
      iflush = 1'b0;
      cycles++;
    end
    exp = expQ.pop_front();
    checkOutput("ihit", {31'd0, ihit}, 32'd1);
    checkOutput("imemload", imemload, exp);
    checkOutput("latency", cycles, expectHit ? 0 : waitN + 2);
    checkOutput("renCycles", renCycles, expectHit ? 0 : waitN + 1);
    if (!expectHit) expMisses++;
    expHits++;
    @(negedge CLK);
    #1;
    imemREN = 1'b0;
    #1;
  endtask

  initial begin
    #1;
    checkOutput("rst_ihit", {31'd0, ihit}, 32'd0);
    checkOutput("rst_imemload", imemload, 32'd0);
    checkOutput("rst_iREN", {31'd0, iREN}, 32'd0);
    checkOutput("rst_iaddr", iaddr, 32'd0);
    checkCounters("rst");
    @(negedge CLK);
    RST = 1'b0;
    #1;

    // Cold miss with three wait states, then a hit ignoring the low address bits.
    waitN = 3;
    applyStimulus(32'h40, 1'b0, 1'b0);
    checkCounters("cold");
    applyStimulus(32'h43, 1'b1, 1'b0);

    // Conflict eviction on index 0.
    waitN = 1;
    applyStimulus(32'h80, 1'b0, 1'b0);
    applyStimulus(32'h40, 1'b0, 1'b0);
    checkOutput("conflict_misses", miss_count, 32'd3);

    // Idle: no request, nothing happens.
    imemaddr = 32'h40;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      #1;
      checkOutput("idle_ihit", {31'd0, ihit}, 32'd0);
      checkOutput("idle_iREN", {31'd0, iREN}, 32'd0);
    end
    checkCounters("idle");

    // Address change mid-fill: the latched fill completes untouched.
    waitN = 2;
    imemREN = 1'b1;
    imemaddr = 32'h100;
    @(negedge CLK);
    #1;
    imemaddr = 32'h200;
    begin
      int fc;
      fc = 0;
      while (iREN && fc < 20) begin
        checkOutput("mid_iaddr", iaddr, 32'h100);
        fc++;
        @(negedge CLK);
        #1;
      end
      checkOutput("mid_fetchCycles", fc, waitN + 1);
    end
    expMisses++;
    checkOutput("mid_newAddrMiss", {31'd0, ihit}, 32'd0);
    imemaddr = 32'h100;
    #1;
    checkOutput("mid_oldResident", {31'd0, ihit}, 32'd1);
    checkOutput("mid_oldData", imemload, memWord(32'h100));
    @(negedge CLK);
    #1;
    expHits++;
    imemREN = 1'b0;
    checkCounters("mid");

    // Flush invalidates resident lines but leaves counters alone.
    waitN = 0;
    applyStimulus(32'h0, 1'b0, 1'b0);
    applyStimulus(32'h4, 1'b0, 1'b0);
    applyStimulus(32'h0, 1'b1, 1'b0);
    applyStimulus(32'h4, 1'b1, 1'b0);
    iflush = 1'b1;
    @(negedge CLK);
    #1;
    iflush = 1'b0;
    checkCounters("flush");
    applyStimulus(32'h0, 1'b0, 1'b0);
    applyStimulus(32'h4, 1'b0, 1'b1);
    applyStimulus(32'h4, 1'b1, 1'b0);
    checkCounters("flushFill");

    // Reset during a fill drops the request and clears everything.
    waitN = 5;
    imemREN = 1'b1;
    imemaddr = 32'h8;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checkOutput("pre_rst_iREN", {31'd0, iREN}, 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("midrst_iREN", {31'd0, iREN}, 32'd0);
    checkOutput("midrst_iaddr", iaddr, 32'd0);
    expHits = 0;
    expMisses = 0;
    checkCounters("midrst");
    imemREN = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    #1;
    applyStimulus(32'h8, 1'b0, 1'b0);
    checkCounters("afterRst");

    $display("test done: total=%0d bad=%0d", checkCount, badCount);
    $finish;
  end

endmodule
